simple: RTL and testbench
=========================

// Module: simple
// PURPOSE
// - Mealy run detector: out asserts in any cycle where input w is 1 and was also 1
//   on the preceding RUN_LEN-1 sampled clock edges.
// - Sits behind clock_divider, which supplies a slow clk so board switches can drive w.
// - Output is shown on an LED.
// PARAMETERS
// - RUN_LEN  2   consecutive 1s needed for detection; legal range 1..255.
// - CNT_W    16  width of det_count; used only when SIMPLE_DETECT_COUNT_EN is defined.
// PORTS
// - clk        in   1      single clock; all state updates on posedge.
// - reset      in   1      synchronous, active-high.
// - w          in   1      serial input, sampled on posedge clk.
// - out        out  1      Mealy detect output (combinational from state and w).
// - det_count  out  CNT_W  detection-cycle count; present only with SIMPLE_DETECT_COUNT_EN.
// BEHAVIOUR
// - Interface: one clock (clk); reset is synchronous and active-high (reset).
// - State:
//   - run_cnt = number of consecutive 1s sampled on w, saturating at RUN_LEN-1.
//   - Width: $clog2(RUN_LEN+1) bits.
// - FSM view for RUN_LEN=2:
//   - States: NONE (run_cnt=0), GOT_ONE (run_cnt>=1).
//   - NONE --w=1--> GOT_ONE. GOT_ONE --w=1--> GOT_ONE.
//   - Any state --w=0--> NONE.
// - Next state on each posedge:
//   - reset=1: run_cnt <= 0.
//   - else w=1: run_cnt <= min(run_cnt+1, RUN_LEN-1).
//   - else: run_cnt <= 0.
// - Output: out = ~reset & w & (run_cnt == RUN_LEN-1).
//   - out is Mealy, so it follows w within the same cycle and drops the moment w goes 0.
//   - No register sits on out.
// - Reset:
//   - While reset=1, out=0 regardless of w.
//   - The first cycle after reset starts with run_cnt=0.
// - Boundary cases:
//   - RUN_LEN=1: out = w & ~reset.
//   - A long run of 1s keeps out=1 every cycle after the first RUN_LEN-1 cycles.
//   - Saturation means there is no wrap-around.
//   - A single 0 in the middle of a run restarts the count.
//   - reset asserted mid-run clears run_cnt on the next edge; out is 0 immediately.
// - Latency: out responds to w with zero cycles of delay, once the history condition is met.
// CONFIGURATION
// - SIMPLE_DETECT_COUNT_EN defined:
//   - Adds the det_count port.
//   - det_count increments on each posedge where out=1 (sampled pre-edge).
//   - It saturates at 2^CNT_W-1 and is cleared to 0 by reset.
// - Macro undefined: no det_count port and no counter logic. Behaviour is otherwise identical.
// STRUCTURE
// - Package simple_pkg holds:
//   - the state enum {S_NONE, S_GOT_ONE} for the RUN_LEN=2 view;
//   - localparam DEFAULT_RUN_LEN=2;
//   - function sat_inc(value, max).
// - One sub-module, simple_run_counter:
//   - a saturating up-counter with synchronous clear and enable;
//   - instantiated once for run_cnt, and once more for det_count when enabled.
// - clock_divider is a separate sibling, not contained here:
//   - ports clock, reset → divided_clocks[31:0];
//   - a 32-bit up-counter, synchronously reset to 0, that increments every clock;
//   - bit k is clock/2^(k+1); the top level selects bit 25 for board use.
// TESTING (RUN_LEN=2, one line = one posedge)
// - T1 reset: reset=1 for 1 cycle with w=X → out=0, run_cnt=0 afterwards.
// - T2 idle: w=0 for 4 cycles → out=0 throughout.
// - T3 single pulse: w=1 for 1 cycle, then w=0 → out=0 in both cycles.
// - T4 long run: w=1 for 4 cycles → out=0,1,1,1. Then w=0 → out=0 at once and stays 0 for 2 cycles.
// - T5 reset mid-run: w=1 for 3 cycles, reset=1 during the 3rd → out=0 in that cycle.
//   - Next cycle, with w=1 and reset=0 → out=0. The cycle after → out=1.
// - T6 SIMPLE_DETECT_COUNT_EN, CNT_W=2: w=1 for 6 cycles → det_count ends at 3 (saturated).
//   - reset → det_count=0.

Source files
------------

// File: rtl/simple_pkg.sv
// Shared types and helpers for the simple run detector.
// Latency: n/a. Backpressure: n/a.
package simple_pkg;

  // Two-state view of run_cnt when RUN_LEN is 2.
  typedef enum logic {
    S_NONE    = 1'b0,
    S_GOT_ONE = 1'b1
  } state_t;

  localparam int DEFAULT_RUN_LEN = 2;

  function automatic logic [31:0] sat_inc(input logic [31:0] value, input logic [31:0] max);
    return (value >= max) ? max : value + 32'd1;
  endfunction

endpackage

// File: rtl/simple_run_counter.sv
// Saturating up-counter with synchronous clear and enable. Clear wins over enable.
// Latency: q updates one edge after clr/en. Backpressure: none.
module simple_run_counter
  import simple_pkg::*;
#(
  parameter int             W   = 2,
  parameter logic [W-1:0]   MAX = {W{1'b1}}
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] q
);

  if (W < 1 || W > 32) begin : g_bad_w
    $error("simple_run_counter: W must be 1..32");
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      q <= '0;
    end else if (en) begin
      q <= W'(sat_inc(32'(q), 32'(MAX)));
    end
  end

endmodule

// File: rtl/simple.sv
// Mealy run detector: out=1 while w has been 1 for RUN_LEN consecutive edges. SIMPLE_DETECT_COUNT_EN adds det_count.
// Latency: out is combinational from run_cnt and w (zero cycles). Backpressure: none.
module simple
  import simple_pkg::*;
#(
  parameter int RUN_LEN = DEFAULT_RUN_LEN,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             w,
  output logic             out
`ifdef SIMPLE_DETECT_COUNT_EN
  ,
  output logic [CNT_W-1:0] det_count
`endif
);

  localparam int             RC_W   = $clog2(RUN_LEN + 1);
  localparam logic [RC_W-1:0] RC_MAX = RC_W'(RUN_LEN - 1);

  if (RUN_LEN < 1 || RUN_LEN > 255) begin : g_bad_run_len
    $error("simple: RUN_LEN must be 1..255");
  end
  if (CNT_W < 1 || CNT_W > 32) begin : g_bad_cnt_w
    $error("simple: CNT_W must be 1..32");
  end

  logic [RC_W-1:0] run_cnt;

  // A 0 on w restarts the run; saturation at RUN_LEN-1 keeps long runs detected.
  simple_run_counter #(
    .W   (RC_W),
    .MAX (RC_MAX)
  ) u_run_cnt (
    .clk (clk),
    .clr (reset | ~w),
    .en  (w),
    .q   (run_cnt)
  );

  assign out = ~reset & w & (run_cnt == RC_MAX);

`ifdef SIMPLE_DETECT_COUNT_EN
  simple_run_counter #(
    .W   (CNT_W),
    .MAX ({CNT_W{1'b1}})
  ) u_det_count (
    .clk (clk),
    .clr (reset),
    .en  (out),
    .q   (det_count)
  );
`endif

endmodule

// File: tb/tb_simple.sv
// Directed bench for simple: three instances (RUN_LEN 1, 2, 3) share one stimulus stream.
// Inputs change on negedge; outputs are sampled 1 time unit later.
module tb_simple;

  logic clk = 1'b0;
  logic reset;
  logic w;
  logic out1, out2, out3;
`ifdef SIMPLE_DETECT_COUNT_EN
  logic [1:0] det1, det2, det3;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  simple #(.RUN_LEN(1), .CNT_W(2)) u_len1 (
    .clk(clk), .reset(reset), .w(w), .out(out1)
`ifdef SIMPLE_DETECT_COUNT_EN
    , .det_count(det1)
`endif
  );
  simple #(.RUN_LEN(2), .CNT_W(2)) u_len2 (
    .clk(clk), .reset(reset), .w(w), .out(out2)
`ifdef SIMPLE_DETECT_COUNT_EN
    , .det_count(det2)
`endif
  );
  simple #(.RUN_LEN(3), .CNT_W(2)) u_len3 (
    .clk(clk), .reset(reset), .w(w), .out(out3)
`ifdef SIMPLE_DETECT_COUNT_EN
    , .det_count(det3)
`endif
  );

  // One call = one cycle: inputs applied after negedge, latched by the following posedge.
  task automatic drive(input logic wv, input logic rv);
    @(negedge clk);
    w     = wv;
    reset = rv;
    #1;
  endtask

  task automatic test_reset();
    logic w_s [3] = '{1'bx, 1'b1, 1'b0};
    logic r_s [3] = '{1'b1, 1'b0, 1'b0};
    logic e1  [3] = '{1'b0, 1'b1, 1'b0};
    logic e2  [3] = '{1'b0, 1'b0, 1'b0};
    logic e3  [3] = '{1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 3; i++) begin
      drive(w_s[i], r_s[i]);
      checks += 3;
      if (out1 !== e1[i]) begin failures++; $display("FAIL reset[%0d] len1 out=%b exp=%b", i, out1, e1[i]); end
      if (out2 !== e2[i]) begin failures++; $display("FAIL reset[%0d] len2 out=%b exp=%b", i, out2, e2[i]); end
      if (out3 !== e3[i]) begin failures++; $display("FAIL reset[%0d] len3 out=%b exp=%b", i, out3, e3[i]); end
    end
  endtask

  task automatic test_idle();
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b0);
      checks += 3;
      if (out1 !== 1'b0) begin failures++; $display("FAIL idle[%0d] len1 out=%b exp=0", i, out1); end
      if (out2 !== 1'b0) begin failures++; $display("FAIL idle[%0d] len2 out=%b exp=0", i, out2); end
      if (out3 !== 1'b0) begin failures++; $display("FAIL idle[%0d] len3 out=%b exp=0", i, out3); end
    end
  endtask

  task automatic test_single_pulse();
    logic w_s [2] = '{1'b1, 1'b0};
    logic e1  [2] = '{1'b1, 1'b0};
    for (int i = 0; i < 2; i++) begin
      drive(w_s[i], 1'b0);
      checks += 3;
      if (out1 !== e1[i]) begin failures++; $display("FAIL pulse[%0d] len1 out=%b exp=%b", i, out1, e1[i]); end
      if (out2 !== 1'b0)  begin failures++; $display("FAIL pulse[%0d] len2 out=%b exp=0", i, out2); end
      if (out3 !== 1'b0)  begin failures++; $display("FAIL pulse[%0d] len3 out=%b exp=0", i, out3); end
    end
  endtask

  task automatic test_long_run();
    logic w_s [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic e1  [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic e2  [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic e3  [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 6; i++) begin
      drive(w_s[i], 1'b0);
      checks += 3;
      if (out1 !== e1[i]) begin failures++; $display("FAIL long_run[%0d] len1 out=%b exp=%b", i, out1, e1[i]); end
      if (out2 !== e2[i]) begin failures++; $display("FAIL long_run[%0d] len2 out=%b exp=%b", i, out2, e2[i]); end
      if (out3 !== e3[i]) begin failures++; $display("FAIL long_run[%0d] len3 out=%b exp=%b", i, out3, e3[i]); end
    end
  endtask

  task automatic test_reset_mid_run();
    logic r_s [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic w_s [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic e1  [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    logic e2  [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    logic e3  [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 6; i++) begin
      drive(w_s[i], r_s[i]);
      checks += 3;
      if (out1 !== e1[i]) begin failures++; $display("FAIL reset_mid[%0d] len1 out=%b exp=%b", i, out1, e1[i]); end
      if (out2 !== e2[i]) begin failures++; $display("FAIL reset_mid[%0d] len2 out=%b exp=%b", i, out2, e2[i]); end
      if (out3 !== e3[i]) begin failures++; $display("FAIL reset_mid[%0d] len3 out=%b exp=%b", i, out3, e3[i]); end
    end
  endtask

  // A single 0 inside a run restarts the count.
  task automatic test_gap();
    logic w_s [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    logic e2  [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    logic e3  [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 6; i++) begin
      drive(w_s[i], 1'b0);
      checks += 3;
      if (out1 !== w_s[i]) begin failures++; $display("FAIL gap[%0d] len1 out=%b exp=%b", i, out1, w_s[i]); end
      if (out2 !== e2[i])  begin failures++; $display("FAIL gap[%0d] len2 out=%b exp=%b", i, out2, e2[i]); end
      if (out3 !== e3[i])  begin failures++; $display("FAIL gap[%0d] len3 out=%b exp=%b", i, out3, e3[i]); end
    end
  endtask

  // Starts from a broken run; a long run must never wrap the run counter.
  task automatic test_saturation();
    drive(1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 1'b0);
      checks += 2;
      if (out2 !== (i >= 1)) begin failures++; $display("FAIL sat[%0d] len2 out=%b exp=%b", i, out2, (i >= 1)); end
      if (out3 !== (i >= 2)) begin failures++; $display("FAIL sat[%0d] len3 out=%b exp=%b", i, out3, (i >= 2)); end
    end
    drive(1'b0, 1'b0);
    checks += 1;
    if (out2 !== 1'b0) begin failures++; $display("FAIL sat_drop len2 out=%b exp=0", out2); end
  endtask

`ifdef SIMPLE_DETECT_COUNT_EN
  task automatic test_det_count();
    drive(1'b0, 1'b1);
    drive(1'b1, 1'b0);
    checks += 3;
    if (det1 !== 2'd0) begin failures++; $display("FAIL det_reset len1 det=%0d exp=0", det1); end
    if (det2 !== 2'd0) begin failures++; $display("FAIL det_reset len2 det=%0d exp=0", det2); end
    if (det3 !== 2'd0) begin failures++; $display("FAIL det_reset len3 det=%0d exp=0", det3); end
    drive(1'b1, 1'b0);
    drive(1'b1, 1'b0);
    checks += 2;
    if (det2 !== 2'd1) begin failures++; $display("FAIL det_mid len2 det=%0d exp=1", det2); end
    if (det3 !== 2'd0) begin failures++; $display("FAIL det_mid len3 det=%0d exp=0", det3); end
    drive(1'b1, 1'b0);
    drive(1'b1, 1'b0);
    drive(1'b1, 1'b0);
    drive(1'b0, 1'b0);
    checks += 3;
    if (det1 !== 2'd3) begin failures++; $display("FAIL det_sat len1 det=%0d exp=3", det1); end
    if (det2 !== 2'd3) begin failures++; $display("FAIL det_sat len2 det=%0d exp=3", det2); end
    if (det3 !== 2'd3) begin failures++; $display("FAIL det_sat len3 det=%0d exp=3", det3); end
    drive(1'b0, 1'b1);
    drive(1'b0, 1'b0);
    checks += 1;
    if (det2 !== 2'd0) begin failures++; $display("FAIL det_clear len2 det=%0d exp=0", det2); end
  endtask
`endif

  initial begin
    w     = 1'b0;
    reset = 1'b1;
    test_reset();
    test_idle();
    test_single_pulse();
    test_long_run();
    test_reset_mid_run();
    test_gap();
    test_saturation();
`ifdef SIMPLE_DETECT_COUNT_EN
    test_det_count();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
